// File: rtl/rob_if.sv
// Reorder-buffer bus: dispatch and completion into the ROB, retirement and
// recovery back out toward the freelist and front end.
interface rob_if #(
   parameter int unsigned WAYS   = 2,
   parameter int unsigned ROB_SZ = 32,
   parameter int unsigned PR_W   = 6,
   parameter int unsigned AR_W   = 5,
   parameter int unsigned RI_W   = $clog2(ROB_SZ)
);
   logic [WAYS-1:0]      dispatch_valid;
   logic [WAYS*PR_W-1:0] dispatch_t_idx;
   logic [WAYS*PR_W-1:0] dispatch_told_idx;
   logic [WAYS*AR_W-1:0] dispatch_ar_idx;
   logic [WAYS*RI_W-1:0] dispatch_rob_idx;
   logic [RI_W:0]        free_slots;
   logic [WAYS-1:0]      complete_valid;
   logic [WAYS*RI_W-1:0] complete_rob_idx;
   logic [WAYS-1:0]      complete_mispredict;
   logic [WAYS-1:0]      retire_valid;
   logic [WAYS*PR_W-1:0] retire_t_idx;
   logic [WAYS*PR_W-1:0] retire_told_idx;
   logic [WAYS*AR_W-1:0] retire_ar_idx;
   logic                 br_recover_enable;

   modport master (
      output dispatch_valid, dispatch_t_idx, dispatch_told_idx, dispatch_ar_idx,
      output complete_valid, complete_rob_idx, complete_mispredict,
      input  dispatch_rob_idx, free_slots,
      input  retire_valid, retire_t_idx, retire_told_idx, retire_ar_idx,
      input  br_recover_enable
   );

   modport slave (
      input  dispatch_valid, dispatch_t_idx, dispatch_told_idx, dispatch_ar_idx,
      input  complete_valid, complete_rob_idx, complete_mispredict,
      output dispatch_rob_idx, free_slots,
      output retire_valid, retire_t_idx, retire_told_idx, retire_ar_idx,
      output br_recover_enable
   );
endinterface

// File: rtl/rob.sv
// In-order reorder buffer: allocates per dispatch, tracks completion, retires up
// to WAYS entries per cycle in order and flushes on a retiring mispredicted branch.
module rob #(
   parameter int unsigned WAYS   = 2,
   parameter int unsigned ROB_SZ = 32,
   parameter int unsigned PR_W   = 6,
   parameter int unsigned AR_W   = 5,
   parameter int unsigned RI_W   = $clog2(ROB_SZ)
) (
   input logic clock,
   input logic reset,
   rob_if.slave rob_io
);

   logic [ROB_SZ-1:0] valid_q, cmpl_q, misp_q;
   logic [PR_W-1:0]   t_q    [ROB_SZ];
   logic [PR_W-1:0]   told_q [ROB_SZ];
   logic [AR_W-1:0]   ar_q   [ROB_SZ];
   logic [RI_W-1:0]   head_q, tail_q;
   logic [RI_W:0]     count_q, count_d, free_slots_q;

   logic [WAYS-1:0]   retire_c, accept_c;
   logic              recover_c, blocked_c;
   logic [RI_W:0]     n_ret_c, n_acc_c;
   logic [RI_W-1:0]   ret_idx_c  [WAYS];
   logic [RI_W-1:0]   disp_idx_c [WAYS];

   // Retirement reads only registered state; a mispredicted branch ends the group.
   always_comb begin
      retire_c  = '0;
      recover_c = 1'b0;
      blocked_c = 1'b0;
      n_ret_c   = '0;
      for (int k = 0; k < WAYS; k++) begin
         ret_idx_c[k] = head_q + RI_W'(k);
         if (!blocked_c && valid_q[ret_idx_c[k]] && cmpl_q[ret_idx_c[k]]) begin
            retire_c[k] = 1'b1;
            n_ret_c     = n_ret_c + (RI_W+1)'(1);
            if (misp_q[ret_idx_c[k]]) begin
               recover_c = 1'b1;
               blocked_c = 1'b1;
            end
         end else begin
            blocked_c = 1'b1;
         end
      end
   end

   // Accept lanes up to the registered free count; same-cycle retires are not credited.
   always_comb begin
      accept_c = '0;
      n_acc_c  = '0;
      for (int j = 0; j < WAYS; j++) begin
         disp_idx_c[j] = tail_q + RI_W'(j);
         if (rob_io.dispatch_valid[j] && ((RI_W+1)'(j) < free_slots_q)) begin
            accept_c[j] = 1'b1;
            n_acc_c     = n_acc_c + (RI_W+1)'(1);
         end
      end
      count_d = count_q + n_acc_c - n_ret_c;
   end

   always_comb begin
      rob_io.dispatch_rob_idx = '0;
      rob_io.retire_t_idx     = '0;
      rob_io.retire_told_idx  = '0;
      rob_io.retire_ar_idx    = '0;
      for (int j = 0; j < WAYS; j++) begin
         rob_io.dispatch_rob_idx[j*RI_W +: RI_W] = disp_idx_c[j];
         rob_io.retire_t_idx[j*PR_W +: PR_W]     = t_q[ret_idx_c[j]];
         rob_io.retire_told_idx[j*PR_W +: PR_W]  = told_q[ret_idx_c[j]];
         rob_io.retire_ar_idx[j*AR_W +: AR_W]    = ar_q[ret_idx_c[j]];
      end
   end

   assign rob_io.retire_valid      = retire_c;
   assign rob_io.br_recover_enable = recover_c;
   assign rob_io.free_slots        = free_slots_q;

   // Entry status and pointers; order inside the else-branch lets dispatch win last.
   always_ff @(posedge clock) begin
      if (reset || recover_c) begin
         valid_q      <= '0;
         cmpl_q       <= '0;
         misp_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         free_slots_q <= (RI_W+1)'(ROB_SZ);
      end else begin
         for (int j = 0; j < WAYS; j++) begin
            if (rob_io.complete_valid[j] &&
                valid_q[rob_io.complete_rob_idx[j*RI_W +: RI_W]]) begin
               cmpl_q[rob_io.complete_rob_idx[j*RI_W +: RI_W]] <= 1'b1;
               if (rob_io.complete_mispredict[j])
                  misp_q[rob_io.complete_rob_idx[j*RI_W +: RI_W]] <= 1'b1;
            end
         end
         for (int k = 0; k < WAYS; k++) begin
            if (retire_c[k]) valid_q[ret_idx_c[k]] <= 1'b0;
         end
         for (int j = 0; j < WAYS; j++) begin
            if (accept_c[j]) begin
               valid_q[disp_idx_c[j]] <= 1'b1;
               cmpl_q[disp_idx_c[j]]  <= 1'b0;
               misp_q[disp_idx_c[j]]  <= 1'b0;
            end
         end
         head_q       <= head_q + n_ret_c[RI_W-1:0];
         tail_q       <= tail_q + n_acc_c[RI_W-1:0];
         count_q      <= count_d;
         free_slots_q <= (RI_W+1)'(ROB_SZ) - count_d;
      end
   end

   // Payload storage needs no reset; it is only observed behind valid.
   always_ff @(posedge clock) begin
      for (int j = 0; j < WAYS; j++) begin
         if (!reset && !recover_c && accept_c[j]) begin
            t_q[disp_idx_c[j]]    <= rob_io.dispatch_t_idx[j*PR_W +: PR_W];
            told_q[disp_idx_c[j]] <= rob_io.dispatch_told_idx[j*PR_W +: PR_W];
            ar_q[disp_idx_c[j]]   <= rob_io.dispatch_ar_idx[j*AR_W +: AR_W];
         end
      end
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- In-order reorder buffer between dispatch and the physical-register freelist.
- Allocates one entry per dispatched instruction and records completion.
- Retires up to SUPERSCALAR_WAYS completed instructions per cycle in program order, handing each retiring instruction's T_old to the freelist.
- On retirement of a mispredicted branch, raises br_recover_enable and flushes itself.

Parameters:
WAYS, `SUPERSCALAR_WAYS (2), dispatch/complete/retire lanes
ROB_SZ, 32, entries; power of two, >= 2*WAYS
PR_W, 6, physical register index width (log2 `N_PHYS_REG)
AR_W, 5, architectural register index width (log2 `N_ARCH_REG)
RI_W, log2(ROB_SZ), ROB index width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
dispatch_valid  in  WAYS  lane j allocates an entry; contiguous from lane 0
dispatch_t_idx  in  WAYS*PR_W  new physical dest (T)
dispatch_told_idx  in  WAYS*PR_W  previous mapping of dest (T_old)
dispatch_ar_idx  in  WAYS*AR_W  architectural dest
dispatch_rob_idx  out  WAYS*RI_W  index lane j would occupy: tail+j mod ROB_SZ
free_slots  out  RI_W+1  registered count of empty entries
complete_valid  in  WAYS  execution finished for complete_rob_idx
complete_rob_idx  in  WAYS*RI_W  entry completing
complete_mispredict  in  WAYS  completing branch was mispredicted
retire_valid  out  WAYS  lane j retires this cycle
retire_t_idx  out  WAYS*PR_W  T of retiring entry
retire_told_idx  out  WAYS*PR_W  T_old to return to freelist
retire_ar_idx  out  WAYS*AR_W  architectural dest of retiring entry
br_recover_enable  out  1  mispredicted branch retiring this cycle

Behaviour:
- Per-entry state: valid, complete, mispredict, T, T_old, AR. Registers: head, tail (RI_W, wrap mod ROB_SZ), count (RI_W+1).
- Reset: all entry valid/complete/mispredict = 0; head = tail = 0; count = 0. Outputs: free_slots = ROB_SZ, retire_valid = 0, br_recover_enable = 0. Reset wins over every other input in the same cycle.
- Dispatch:
  - Lane j is written at tail+j only if dispatch_valid[j] and j < free_slots. Lanes beyond free_slots are dropped silently.
  - Written entries: valid = 1, complete = 0, mispredict = 0.
  - tail advances by the number of accepted lanes.
  - free_slots does not credit same-cycle retirements, so it is conservative by one cycle.
- Completion:
  - Sets complete at the next edge. mispredict |= complete_mispredict.
  - Completion to an invalid entry is ignored. Repeated completion is idempotent.
  - Complete-to-retire latency is at least 1 cycle: retire logic reads only registered complete bits.
- Retirement (combinational from registered state, same cycle):
  - Lane k retires entry head+k iff lanes 0..k-1 retire, entry is valid and complete, and no earlier lane in this cycle is a mispredicted branch.
  - Retired entries are invalidated at the edge. head advances by the retired count.
  - count_next = count + accepted - retired.
- Recovery:
  - If a retiring lane's entry has mispredict = 1, br_recover_enable = 1 in that cycle.
  - That branch retires (its T_old is presented). Later lanes do not retire.
  - At the edge: all entries invalidated, head = tail = 0, count = 0. Same-cycle dispatch and completion are discarded.
  - br_recover_enable is a 1-cycle pulse per mispredicted branch.
- Full: count = ROB_SZ gives free_slots = 0; all dispatch dropped. Retirement still proceeds.
- Empty: count = 0 gives retire_valid = 0; dispatch_rob_idx still reports tail-based indices.
- Wrap-around: tail+j and head+k are taken mod ROB_SZ. Full and empty are distinguished by count, never by pointer equality.
- Retire-lane outputs (t/told/ar) are don't-care when the corresponding retire_valid bit is 0. Benches compare them only when valid.

Test Plan:
- Reset, then idle: free_slots = 32, retire_valid = 00, br_recover_enable = 0, dispatch_rob_idx = {1,0}.
- Dispatch 2 (T = 32/33, T_old = 1/2); complete both next cycle. One cycle later retire_valid = 11, retire_told_idx = {2,1}, free_slots returns to 32.
- Out-of-order completion: dispatch 4 entries; complete idx 1, 2, 3 first. Expect no retire. Then complete idx 0. Next cycle retire idx 0, 1; following cycle retire idx 2, 3.
- Mispredict: entries 0 (branch, mispredict) and 1 both complete. Expect retire_valid = 01, br_recover_enable = 1 for one cycle. Next cycle free_slots = 32, head = tail = 0, and entry 1 never retires.
- Fill to 32 (free_slots = 0). Extra dispatch dropped. Retire 2 and refill across the wrap: dispatch_rob_idx = {1,0} after head = 2 and tail = 0. Contents retire in order.
- Reset asserted mid-stream with 10 valid entries plus a same-cycle dispatch and completion. Next cycle all outputs are at reset values and nothing retires.
